// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch redirect and multi-cycle mul/div hand-off.
// Holds EX while the ALU iterates, buffers the result across MEM stalls, and gates ALU restarts.
module ex_mem_stage #(
  parameter int XLEN          = 32,
  parameter int REG_ADDR_BITS = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_ex_valid,
  input  logic                     i_ex_is_md,
  input  logic                     i_ex_branch,
  input  logic [XLEN-1:0]          i_ex_target,
  input  logic [REG_ADDR_BITS-1:0] i_ex_rd,
  input  logic                     i_ex_reg_write,
  input  logic                     i_ex_mem_read,
  input  logic                     i_ex_mem_write,
  input  logic [XLEN-1:0]          i_ex_wdata,
  input  logic [XLEN-1:0]          i_alu_result,
  input  logic                     i_alu_is_zero,
  input  logic                     i_alu_ready,
  input  logic                     i_mem_stall,
  input  logic                     i_flush,
  output logic                     o_stall_ex,
  output logic                     o_md_enable,
  output logic                     o_mem_valid,
  output logic                     o_mem_reg_write,
  output logic                     o_mem_mem_read,
  output logic                     o_mem_mem_write,
  output logic [XLEN-1:0]          o_mem_result,
  output logic [XLEN-1:0]          o_mem_wdata,
  output logic [REG_ADDR_BITS-1:0] o_mem_rd,
  output logic                     o_redirect_valid,
  output logic [XLEN-1:0]          o_redirect_pc,
  output logic                     o_busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MD_WAIT  = 2'd1,
    MD_HOLD  = 2'd2,
    MD_DRAIN = 2'd3
  } state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic                     w_live;
  logic                     w_stall;
  logic                     w_md_en;
  logic                     w_load_ex;
  logic                     w_load_buf;
  logic [XLEN-1:0]          r_md_buf;
  logic                     r_mem_valid;
  logic                     r_mem_reg_write;
  logic                     r_mem_mem_read;
  logic                     r_mem_mem_write;
  logic [XLEN-1:0]          r_mem_result;
  logic [XLEN-1:0]          r_mem_wdata;
  logic [REG_ADDR_BITS-1:0] r_mem_rd;

  assign w_live = i_ex_valid & ~i_flush;

  // Next-state, EX hold, ALU start gating and EX/MEM load selection
  always_comb begin
    w_next     = r_state;
    w_stall    = 1'b0;
    w_md_en    = 1'b0;
    w_load_ex  = 1'b0;
    w_load_buf = 1'b0;
    case (r_state)
      IDLE: begin
        w_md_en = 1'b1;
        if (w_live && i_ex_is_md) begin
          w_stall = 1'b1;
          w_next  = MD_WAIT;
        end else if (w_live) begin
          w_stall   = i_mem_stall;
          w_load_ex = ~i_mem_stall;
        end else begin
          w_stall = 1'b0;
        end
      end
      MD_WAIT: begin
        w_md_en = 1'b1;
        // A flush coinciding with ready has nothing left to drain
        if (i_flush) begin
          w_next = i_alu_ready ? IDLE : MD_DRAIN;
        end else if (i_alu_ready && !i_mem_stall) begin
          w_load_ex = 1'b1;
          w_next    = IDLE;
        end else if (i_alu_ready) begin
          w_stall = 1'b1;
          w_next  = MD_HOLD;
        end else begin
          w_stall = 1'b1;
        end
      end
      MD_HOLD: begin
        if (i_flush) begin
          w_next = IDLE;
        end else if (!i_mem_stall) begin
          w_load_buf = 1'b1;
          w_next     = IDLE;
        end else begin
          w_stall = 1'b1;
        end
      end
      MD_DRAIN: begin
        if (i_alu_ready) begin
          w_next = IDLE;
        end else begin
          w_next = MD_DRAIN;
        end
        if (w_live && i_ex_is_md) begin
          w_stall = 1'b1;
        end else if (w_live) begin
          w_stall   = i_mem_stall;
          w_load_ex = ~i_mem_stall;
        end else begin
          w_stall = 1'b0;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Mul/div result is only valid in the ready cycle, so capture it there
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_md_buf <= {XLEN{1'b0}};
    end else if (r_state == MD_WAIT && i_alu_ready) begin
      r_md_buf <= i_alu_result;
    end
  end

  // EX/MEM pipeline register: load, hold on MEM stall, otherwise bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_valid     <= 1'b0;
      r_mem_reg_write <= 1'b0;
      r_mem_mem_read  <= 1'b0;
      r_mem_mem_write <= 1'b0;
      r_mem_result    <= {XLEN{1'b0}};
      r_mem_wdata     <= {XLEN{1'b0}};
      r_mem_rd        <= {REG_ADDR_BITS{1'b0}};
    end else if (w_load_ex || w_load_buf) begin
      r_mem_valid     <= 1'b1;
      r_mem_reg_write <= i_ex_reg_write;
      r_mem_mem_read  <= i_ex_mem_read;
      r_mem_mem_write <= i_ex_mem_write;
      r_mem_result    <= w_load_buf ? r_md_buf : i_alu_result;
      r_mem_wdata     <= i_ex_wdata;
      r_mem_rd        <= i_ex_rd;
    end else if (i_mem_stall) begin
      r_mem_valid     <= r_mem_valid;
    end else begin
      r_mem_valid     <= 1'b0;
      r_mem_reg_write <= 1'b0;
      r_mem_mem_read  <= 1'b0;
      r_mem_mem_write <= 1'b0;
      r_mem_result    <= {XLEN{1'b0}};
      r_mem_wdata     <= {XLEN{1'b0}};
      r_mem_rd        <= {REG_ADDR_BITS{1'b0}};
    end
  end

  // Combinational outputs are forced low while reset is asserted
  assign o_stall_ex       = w_stall & ~rst;
  assign o_md_enable      = w_md_en & ~rst;
  assign o_redirect_valid = i_ex_valid & i_ex_branch & i_alu_is_zero & w_load_ex & ~i_flush & ~rst;
  assign o_redirect_pc    = rst ? {XLEN{1'b0}} : i_ex_target;
  assign o_busy           = (r_state != IDLE);

  assign o_mem_valid      = r_mem_valid;
  assign o_mem_reg_write  = r_mem_reg_write;
  assign o_mem_mem_read   = r_mem_mem_read;
  assign o_mem_mem_write  = r_mem_mem_write;
  assign o_mem_result     = r_mem_result;
  assign o_mem_wdata      = r_mem_wdata;
  assign o_mem_rd         = r_mem_rd;

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

EX/MEM pipeline stage placed directly downstream of the execute ALU. It captures the ALU result and control fields into the EX/MEM register and raises a taken-branch redirect. For multi-cycle multiply/divide operations it holds the upstream pipeline until the ALU's one-cycle `ready` pulse, then buffers the result if MEM is stalled. It also gates the ALU's mult/div start so that no stale restart or aborted operation leaks a wrong result.

## Interface
- XLEN, 32, datapath width
- REG_ADDR_BITS, 5, destination register index width
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- ex_valid  in  1  EX holds a live instruction
- ex_is_md  in  1  EX instruction is MUL*/DIV*/REM*
- ex_branch  in  1  EX instruction is branch/JAL/JALR
- ex_target  in  XLEN  redirect target PC
- ex_rd  in  REG_ADDR_BITS  destination register
- ex_reg_write, ex_mem_read, ex_mem_write  in  1 each  control bits
- ex_wdata  in  XLEN  store data
- alu_result  in  XLEN  ALU `result`
- alu_is_zero  in  1  ALU `is_zero` (1 = branch/jump taken)
- alu_ready  in  1  ALU mult/div ready, one-cycle pulse
- mem_stall  in  1  MEM cannot accept this cycle
- flush  in  1  kill the EX instruction
- stall_ex  out  1  hold ID/EX and the PC
- md_enable  out  1  0 = upstream replaces alu_ctrl with ADD (blocks mult/div start)
- mem_valid, mem_reg_write, mem_mem_read, mem_mem_write  out  1 each  EX/MEM register
- mem_result, mem_wdata  out  XLEN  EX/MEM register
- mem_rd  out  REG_ADDR_BITS  EX/MEM register
- redirect_valid  out  1  taken-branch pulse
- redirect_pc  out  XLEN  redirect target
- busy  out  1  state != IDLE

## Operation
- States: IDLE, MD_WAIT, MD_HOLD, MD_DRAIN. Reset → IDLE. All registered outputs are 0 on reset.
- "advance" means the EX instruction leaves EX this cycle and EX/MEM loads it at the edge.
- IDLE, non-md op (ex_valid & !ex_is_md & !flush):
  - stall_ex = mem_stall.
  - When !mem_stall, EX/MEM loads the fields, with mem_result = alu_result.
- IDLE, md op:
  - stall_ex = 1 and md_enable = 1; go to MD_WAIT.
- MD_WAIT: stall_ex = 1.
  - On alu_ready, md_buf ← alu_result.
  - If alu_ready & !mem_stall: load EX/MEM with alu_result, stall_ex = 0 in that same cycle, go to IDLE.
  - If alu_ready & mem_stall: go to MD_HOLD.
- MD_HOLD: stall_ex = 1 and md_enable = 0 (prevents the ALU restarting on the held op).
  - When !mem_stall, load EX/MEM with mem_result = md_buf, stall_ex = 0, go to IDLE.
- flush in IDLE, or with !ex_valid: the EX instruction is discarded, stall_ex = 0, no redirect.
- flush in MD_WAIT: the ALU cannot abort, so go to MD_DRAIN and stall_ex = 0.
- MD_DRAIN: md_enable = 0 until alu_ready, which is ignored; then go to IDLE.
  - During MD_DRAIN, stall_ex = ex_valid & ex_is_md.
  - Non-md ops proceed as in IDLE.
- flush in MD_HOLD: discard md_buf and go to IDLE.
- md_enable = 1 in IDLE and MD_WAIT, 0 in MD_HOLD and MD_DRAIN.
- EX/MEM when not loading:
  - mem_stall = 1: hold contents.
  - Otherwise load a bubble (mem_valid = 0, all control bits 0).
- Redirect:
  - redirect_valid = ex_valid & ex_branch & alu_is_zero & advance & !flush, combinational.
  - redirect_pc = ex_target.
- Priority: rst > flush > mem_stall > normal.

## Timing
- Non-md latency: 1 cycle, EX → mem_valid.
- md latency: with cycle 1 = issue cycle (state IDLE), alu_ready arrives in cycle 34.
  - stall_ex is 1 in cycles 1–33 and 0 in cycle 34.
  - mem_valid is 1 in cycle 35.
  - Each cycle of mem_stall at ready adds one cycle via MD_HOLD.
- The result is captured only in the alu_ready cycle; the ALU output is invalid afterwards.
- md_enable drops in the cycle after ready whenever the op does not advance, so the ALU sees no valid in its IDLE.

## Test plan
- ADD 5+7, no stalls → mem_valid = 1 and mem_result = 12 one cycle later; stall_ex stays 0.
- MUL 0x0000_0003 × 0xFFFF_FFFF (signed) → stall_ex high for cycles 1–33; mem_result = 0xFFFF_FFFD in cycle 35.
- DIVU 100/7 with mem_stall high in cycles 34–36:
  - mem_result = 14 loads at the end of cycle 37.
  - md_enable = 0 in cycles 35–37.
  - The ALU is not restarted.
- REM issued, flush in cycle 10:
  - stall_ex = 0 from cycle 10.
  - A following ADD completes normally.
  - A following DIV stalls until cycle 34 and then takes its full 34 cycles.
- BEQ with alu_is_zero = 1, ex_target = 0x100:
  - redirect_valid pulses for 1 cycle with redirect_pc = 0x100.
  - With mem_stall held high, the pulse is delayed until the stall clears.
- rst asserted mid-MD_WAIT → all outputs 0 and state IDLE immediately, with no clock required.
